// File: rtl/midi_rx_framer.sv
`timescale 1ns/1ps
// midi_rx_framer
// MIDI input front end: 2-FF synchroniser, 8N1 UART receiver, running-status
// message framer with optional channel filter, and an output message FIFO.
//
// Build option: define MIDI_RX_SYSEX_EN to forward system-exclusive traffic
// (F0, each enclosed data byte as {F0,b,len1}, F7). Without it sysex is dropped.
//
// Ports
//   CLOCK_25      in   system clock, all logic on posedge
//   reset         in   synchronous, active-high
//   midi_rxd      in   raw serial input, idle high, asynchronous
//   ch_filter_en  in   1: drop channel messages whose channel != midi_ch
//   midi_ch       in   channel matched when filtering
//   msg_valid     out  FIFO head holds a message
//   msg_ready     in   consumer accepts head when msg_valid && msg_ready
//   msg_status    out  status byte of head message
//   msg_data1     out  first data byte (0 if msg_len < 1)
//   msg_data2     out  second data byte (0 if msg_len < 2)
//   msg_len       out  number of data bytes, 0..2
//   framing_err   out  1-cycle pulse, stop bit sampled low
//   overflow_err  out  1-cycle pulse, message dropped because FIFO full
//   rx_busy       out  receiver not idle
//
// RX states
//   S_IDLE  | waiting for a falling edge on the synchronised line
//   S_START | half-bit wait, then confirm start bit (high = glitch)
//   S_DATA  | sampling 8 data bits, LSB first
//   S_STOP  | sampling the stop bit
module midi_rx_framer #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 31250,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       CLOCK_25,
    input  logic       reset,
    input  logic       midi_rxd,
    input  logic       ch_filter_en,
    input  logic [3:0] midi_ch,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       framing_err,
    output logic       overflow_err,
    output logic       rx_busy
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int TW   = $clog2(DIV);
    localparam int PW   = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // sync_q[1:0] is the synchroniser, sync_q[2] the previous synced value
    logic [2:0]    sync_q;
    logic          rxd_s;
    logic          rxd_fall;
    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          byte_stb;
    logic [7:0]    byte_q;

    assign rxd_s    = sync_q[1];
    assign rxd_fall = sync_q[2] & ~sync_q[1];
    assign rx_busy  = (state != S_IDLE);

    always_ff @(posedge CLOCK_25) begin
        if (reset) sync_q <= 3'b111;
        else       sync_q <= {sync_q[1:0], midi_rxd};
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            state       <= S_IDLE;
            timer       <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            byte_stb    <= 1'b0;
            byte_q      <= '0;
            framing_err <= 1'b0;
        end else begin
            byte_stb    <= 1'b0;
            framing_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rxd_fall) begin
                        state <= S_START;
                        timer <= TW'(HALF - 1);
                    end
                end
                S_START: begin
                    if (timer == '0) begin
                        if (!rxd_s) begin
                            state   <= S_DATA;
                            timer   <= TW'(DIV - 1);
                            bit_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_DATA: begin
                    if (timer == '0) begin
                        shreg <= {rxd_s, shreg[7:1]};
                        timer <= TW'(DIV - 1);
                        if (bit_cnt == 3'd7) state <= S_STOP;
                        else                 bit_cnt <= bit_cnt + 3'd1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    if (timer == '0) begin
                        state <= S_IDLE;
                        if (rxd_s) begin
                            byte_stb <= 1'b1;
                            byte_q   <= shreg;
                        end else begin
                            framing_err <= 1'b1;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
            endcase
        end
    end

    // Framer: run_st == 0 means no running status, so data bytes are dropped
    logic [7:0] run_st, rs_n;
    logic       have_d1, have_d1_n;
    logic [6:0] d1_q, d1_n;
    logic       need2;
    logic       req, req_pass;
    logic [7:0] req_st;
    logic [6:0] req_d1, req_d2;
    logic [1:0] req_len;
    logic       push_q;
    logic [23:0] push_msg;
`ifdef MIDI_RX_SYSEX_EN
    logic       in_sysex, sx_n;
`endif

    assign need2 = !(run_st[7:4] == 4'hC || run_st[7:4] == 4'hD ||
                     run_st == 8'hF1 || run_st == 8'hF3);

    always_comb begin
        rs_n      = run_st;
        have_d1_n = have_d1;
        d1_n      = d1_q;
        req       = 1'b0;
        req_st    = '0;
        req_d1    = '0;
        req_d2    = '0;
        req_len   = '0;
`ifdef MIDI_RX_SYSEX_EN
        sx_n      = in_sysex;
`endif
        if (byte_stb) begin
            if (byte_q >= 8'hF8) begin
                // realtime interleaves anywhere without disturbing framing
                req    = 1'b1;
                req_st = byte_q;
            end else if (byte_q[7]) begin
`ifdef MIDI_RX_SYSEX_EN
                sx_n = 1'b0;
`endif
                case (byte_q)
                    8'hF0: begin
                        rs_n      = 8'h00;
                        have_d1_n = 1'b0;
`ifdef MIDI_RX_SYSEX_EN
                        sx_n   = 1'b1;
                        req    = 1'b1;
                        req_st = byte_q;
`endif
                    end
                    8'hF7: begin
`ifdef MIDI_RX_SYSEX_EN
                        rs_n      = 8'h00;
                        have_d1_n = 1'b0;
                        req       = 1'b1;
                        req_st    = byte_q;
`endif
                    end
                    8'hF4, 8'hF5: begin
                    end
                    8'hF6: begin
                        rs_n      = 8'h00;
                        have_d1_n = 1'b0;
                        req       = 1'b1;
                        req_st    = byte_q;
                    end
                    default: begin
                        rs_n      = byte_q;
                        have_d1_n = 1'b0;
                    end
                endcase
            end else begin
`ifdef MIDI_RX_SYSEX_EN
                if (in_sysex) begin
                    req     = 1'b1;
                    req_st  = 8'hF0;
                    req_d1  = byte_q[6:0];
                    req_len = 2'd1;
                end else
`endif
                if (run_st != 8'h00) begin
                    if (!have_d1 && !need2) begin
                        req     = 1'b1;
                        req_st  = run_st;
                        req_d1  = byte_q[6:0];
                        req_len = 2'd1;
                    end else if (!have_d1) begin
                        d1_n      = byte_q[6:0];
                        have_d1_n = 1'b1;
                    end else begin
                        req       = 1'b1;
                        req_st    = run_st;
                        req_d1    = d1_q;
                        req_d2    = byte_q[6:0];
                        req_len   = 2'd2;
                        have_d1_n = 1'b0;
                    end
                    // system common messages do not establish running status
                    if (req && run_st[7:4] == 4'hF) rs_n = 8'h00;
                end
            end
        end
    end

    assign req_pass = !(ch_filter_en && req_st[7] && req_st[7:4] != 4'hF &&
                        req_st[3:0] != midi_ch);

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            run_st   <= '0;
            have_d1  <= 1'b0;
            d1_q     <= '0;
            push_q   <= 1'b0;
            push_msg <= '0;
`ifdef MIDI_RX_SYSEX_EN
            in_sysex <= 1'b0;
`endif
        end else begin
            run_st   <= rs_n;
            have_d1  <= have_d1_n;
            d1_q     <= d1_n;
            push_q   <= req && req_pass;
            push_msg <= {req_st, req_d1, req_d2, req_len};
`ifdef MIDI_RX_SYSEX_EN
            in_sysex <= sx_n;
`endif
        end
    end

    // Output FIFO, entry = {status, data1, data2, len}
    logic [23:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          pop, full, wr_en;
    logic [23:0]   head;

    assign msg_valid = (count != '0);
    assign pop       = msg_valid && msg_ready;
    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign wr_en     = push_q && (!full || pop);
    assign head      = mem[rd_ptr];

    assign msg_status = msg_valid ? head[23:16] : '0;
    assign msg_data1  = msg_valid ? head[15:9]  : '0;
    assign msg_data2  = msg_valid ? head[8:2]   : '0;
    assign msg_len    = msg_valid ? head[1:0]   : '0;

    always_ff @(posedge CLOCK_25) begin
        if (wr_en) mem[wr_ptr] <= push_msg;
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            overflow_err <= push_q && full && !pop;
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            if (wr_en && !pop)      count <= count + (PW+1)'(1);
            else if (!wr_en && pop) count <= count - (PW+1)'(1);
        end
    end

endmodule

// File: tb/tb_midi_rx_framer.sv
`timescale 1ns/1ps
module tb_midi_rx_framer;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 62500;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int DEPTH  = 16;

    logic       CLOCK_25 = 1'b0;
    logic       reset;
    logic       midi_rxd;
    logic       ch_filter_en;
    logic [3:0] midi_ch;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] msg_status;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;
    logic [1:0] msg_len;
    logic       framing_err;
    logic       overflow_err;
    logic       rx_busy;

    midi_rx_framer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_25     (CLOCK_25),
        .reset        (reset),
        .midi_rxd     (midi_rxd),
        .ch_filter_en (ch_filter_en),
        .midi_ch      (midi_ch),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_status   (msg_status),
        .msg_data1    (msg_data1),
        .msg_data2    (msg_data2),
        .msg_len      (msg_len),
        .framing_err  (framing_err),
        .overflow_err (overflow_err),
        .rx_busy      (rx_busy)
    );

    always #5 CLOCK_25 = ~CLOCK_25;

    typedef struct packed {
        logic [7:0] st;
        logic [6:0] d1;
        logic [6:0] d2;
        logic [1:0] len;
    } msg_t;

    typedef struct {
        logic [47:0] bytes;
        int          nb;
        logic        fen;
        logic [3:0]  ch;
        logic [95:0] exps;
        int          ne;
    } vec_t;

    msg_t sb[$];
    vec_t vecs[$];
    vec_t cur;
    msg_t mon_e;

    int n_chk = 0;
    int n_fail = 0;
    int ferr_hi = 0, ferr_rise = 0, ovf_hi = 0, ovf_rise = 0;
    logic ferr_d = 1'b0, ovf_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge CLOCK_25);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        midi_rxd = 1'b0;
        hold(DIV);
        for (int i = 0; i < 8; i++) begin
            midi_rxd = b[i];
            hold(DIV);
        end
        midi_rxd = stop_v;
        hold(DIV);
        midi_rxd = 1'b1;
    endtask

    task automatic expect_msg(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2,
                              input logic [1:0] len);
        msg_t m;
        m.st = st; m.d1 = d1; m.d2 = d2; m.len = len;
        sb.push_back(m);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            hold(1);
            t++;
        end
        hold(30);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic nv(input int nb, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input logic [7:0] b4, input logic fen, input logic [3:0] ch);
        cur.bytes = {8'h00, b4, b3, b2, b1, b0};
        cur.nb    = nb;
        cur.fen   = fen;
        cur.ch    = ch;
        cur.exps  = '0;
        cur.ne    = 0;
    endtask

    task automatic ex(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2, input logic [1:0] len);
        cur.exps[24*cur.ne +: 24] = {st, d1, d2, len};
        cur.ne++;
    endtask

    // consumer side of the scoreboard
    always @(negedge CLOCK_25) begin
        if (!reset) begin
            ferr_hi  += int'(framing_err);
            ovf_hi   += int'(overflow_err);
            if (framing_err && !ferr_d) ferr_rise++;
            if (overflow_err && !ovf_d) ovf_rise++;
            ferr_d = framing_err;
            ovf_d  = overflow_err;
            if (msg_valid && msg_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_msg: got %h %h %h len %0d, required none",
                             msg_status, msg_data1, msg_data2, msg_len);
                end else begin
                    mon_e = sb.pop_front();
                    chk("msg_status", msg_status, mon_e.st);
                    chk("msg_data1", msg_data1, mon_e.d1);
                    chk("msg_data2", msg_data2, mon_e.d2);
                    chk("msg_len", msg_len, mon_e.len);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, f1, o0, o1;
        vec_t v;

        reset = 1'b1; midi_rxd = 1'b1; msg_ready = 1'b1; ch_filter_en = 1'b0; midi_ch = 4'd0;
        hold(5);
        reset = 1'b0;
        hold(2);
        chk("rst_valid", msg_valid, 0);
        chk("rst_status", msg_status, 0);
        chk("rst_d1", msg_data1, 0);
        chk("rst_d2", msg_data2, 0);
        chk("rst_len", msg_len, 0);
        chk("rst_ferr", framing_err, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_busy", rx_busy, 0);

        nv(3, 8'h90, 8'h3C, 8'h64, 8'h00, 8'h00, 0, 0); ex(8'h90, 7'h3C, 7'h64, 2); vecs.push_back(cur);
        nv(5, 8'h90, 8'h3C, 8'h64, 8'h3E, 8'h00, 0, 0);
        ex(8'h90, 7'h3C, 7'h64, 2); ex(8'h90, 7'h3E, 7'h00, 2); vecs.push_back(cur);
        nv(4, 8'h90, 8'h3C, 8'hF8, 8'h64, 8'h00, 0, 0);
        ex(8'hF8, 0, 0, 0); ex(8'h90, 7'h3C, 7'h64, 2); vecs.push_back(cur);
        nv(2, 8'hC5, 8'h07, 8'h00, 8'h00, 8'h00, 1, 5); ex(8'hC5, 7'h07, 0, 1); vecs.push_back(cur);
        nv(2, 8'hC5, 8'h07, 8'h00, 8'h00, 8'h00, 1, 4); vecs.push_back(cur);
        nv(1, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4); ex(8'hFE, 0, 0, 0); vecs.push_back(cur);
        nv(4, 8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h00, 0, 0);
`ifdef MIDI_RX_SYSEX_EN
        ex(8'hF0, 0, 0, 0); ex(8'hF0, 7'h7E, 0, 1); ex(8'hF0, 7'h01, 0, 1); ex(8'hF7, 0, 0, 0);
`endif
        vecs.push_back(cur);
        nv(1, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0); vecs.push_back(cur);
        nv(3, 8'hE3, 8'h00, 8'h40, 8'h00, 8'h00, 1, 3); ex(8'hE3, 7'h00, 7'h40, 2); vecs.push_back(cur);
        nv(3, 8'hD2, 8'h7F, 8'h7F, 8'h00, 8'h00, 0, 0);
        ex(8'hD2, 7'h7F, 0, 1); ex(8'hD2, 7'h7F, 0, 1); vecs.push_back(cur);
        nv(5, 8'hF0, 8'h01, 8'h90, 8'h3C, 8'h64, 0, 0);
`ifdef MIDI_RX_SYSEX_EN
        ex(8'hF0, 0, 0, 0); ex(8'hF0, 7'h01, 0, 1);
`endif
        ex(8'h90, 7'h3C, 7'h64, 2); vecs.push_back(cur);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            ch_filter_en = v.fen;
            midi_ch      = v.ch;
            for (int k = 0; k < v.ne; k++) sb.push_back(msg_t'(v.exps[24*k +: 24]));
            for (int k = 0; k < v.nb; k++) send_byte(v.bytes[8*k +: 8], 1'b1);
            drain($sformatf("vec%0d_drain", i));
        end
        ch_filter_en = 1'b0;

        // latency: last stop sample -> msg_valid in 2 cycles
        expect_msg(8'h90, 7'h3C, 7'h64, 2);
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        fork
            send_byte(8'h64, 1'b1);
            begin
                int t;
                t = 0;
                while (!rx_busy && t < 400) begin @(negedge CLOCK_25); t++; end
                while (rx_busy && t < 800) begin @(negedge CLOCK_25); t++; end
                chk("lat_busy_timeout", (t < 800) ? 1 : 0, 1);
                chk("lat_valid_c0", msg_valid, 0);
                @(negedge CLOCK_25);
                chk("lat_valid_c1", msg_valid, 0);
                @(negedge CLOCK_25);
                chk("lat_valid_c2", msg_valid, 1);
            end
        join
        drain("lat_drain");

        // framing error then recovery
        f0 = ferr_hi; f1 = ferr_rise;
        send_byte(8'h90, 1'b0);
        hold(DIV);
        chk("ferr_cycles", ferr_hi - f0, 1);
        chk("ferr_pulses", ferr_rise - f1, 1);
        drain("ferr_nomsg");
        expect_msg(8'h80, 7'h40, 7'h00, 2);
        send_byte(8'h80, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h00, 1'b1);
        drain("ferr_recover");

        // start-bit glitch
        f0 = ferr_hi;
        midi_rxd = 1'b0;
        hold(3);
        midi_rxd = 1'b1;
        hold(3 * DIV);
        chk("glitch_busy", rx_busy, 0);
        chk("glitch_ferr", ferr_hi - f0, 0);
        drain("glitch_nomsg");

        // overflow
        msg_ready = 1'b0;
        o0 = ovf_hi; o1 = ovf_rise;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i < DEPTH) expect_msg(8'hF8, 0, 0, 0);
            send_byte(8'hF8, 1'b1);
        end
        hold(10);
        chk("ovf_cycles", ovf_hi - o0, 1);
        chk("ovf_pulses", ovf_rise - o1, 1);
        chk("ovf_valid", msg_valid, 1);
        msg_ready = 1'b1;
        drain("ovf_drain");
        chk("ovf_empty", msg_valid, 0);

        // reset mid-message and mid-byte
        msg_ready = 1'b0;
        send_byte(8'hF8, 1'b1);
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        midi_rxd = 1'b0;
        hold(DIV);
        midi_rxd = 1'b1;
        hold(2 * DIV);
        chk("midrst_valid_before", msg_valid, 1);
        reset = 1'b1;
        midi_rxd = 1'b1;
        sb.delete();
        hold(2);
        chk("midrst_valid", msg_valid, 0);
        chk("midrst_status", msg_status, 0);
        chk("midrst_len", msg_len, 0);
        chk("midrst_busy", rx_busy, 0);
        reset = 1'b0;
        msg_ready = 1'b1;
        hold(2 * DIV);
        send_byte(8'h64, 1'b1);
        drain("midrst_nomsg");
        chk("midrst_valid_after", msg_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
